// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
// Contents: NUM_PORTS, access size encoding (size_e), arbiter FSM states (state_e).
package dmem_pkg;
    localparam int NUM_PORTS = 2;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of both requester ports, both response ports and the memory port.
// Ports: reqN_* (request handshake + payload), rspN_* (completion), mem_* (byte-enabled memory).
// Modports: slave = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid_i, req0_ready_o, req0_we_i;
    logic [1:0]            req0_size_i;
    logic [ADDR_WIDTH-1:0] req0_addr_i;
    logic [DATA_WIDTH-1:0] req0_wdata_i;
    logic                  req1_valid_i, req1_ready_o, req1_we_i;
    logic [1:0]            req1_size_i;
    logic [ADDR_WIDTH-1:0] req1_addr_i;
    logic [DATA_WIDTH-1:0] req1_wdata_i;
    logic                  rsp0_valid_o, rsp0_err_o;
    logic [DATA_WIDTH-1:0] rsp0_rdata_o;
    logic                  rsp1_valid_o, rsp1_err_o;
    logic [DATA_WIDTH-1:0] rsp1_rdata_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o, mem_rdata_i;

    modport slave (
        input  req0_valid_i, req0_we_i, req0_size_i, req0_addr_i, req0_wdata_i,
        input  req1_valid_i, req1_we_i, req1_size_i, req1_addr_i, req1_wdata_i,
        output req0_ready_o, req1_ready_o,
        output rsp0_valid_o, rsp0_err_o, rsp0_rdata_o,
        output rsp1_valid_o, rsp1_err_o, rsp1_rdata_o,
        output mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output req0_valid_i, req0_we_i, req0_size_i, req0_addr_i, req0_wdata_i,
        output req1_valid_i, req1_we_i, req1_size_i, req1_addr_i, req1_wdata_i,
        input  req0_ready_o, req1_ready_o,
        input  rsp0_valid_o, rsp0_err_o, rsp0_rdata_o,
        input  rsp1_valid_o, rsp1_err_o, rsp1_rdata_o,
        input  mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one access.
// Ports: size_i/offs_i (access size, addr[1:0]), wdata_i (right-justified store data),
// rdata_i (raw memory word), be_o (byte enables), wdata_o (lane-shifted store data),
// rdata_o (right-justified, zero-extended load data), err_o (reserved size or misaligned).
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  size_e                 size_i,
    input  logic [1:0]            offs_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic [3:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);
    logic [3:0]            mask;
    logic [DATA_WIDTH-1:0] dmask;
    logic [4:0]            sh;

    always_comb begin
        mask    = size_i == SZ_BYTE ? 4'b0001 : size_i == SZ_HALF ? 4'b0011 :
                  size_i == SZ_WORD ? 4'b1111 : 4'b0000;
        dmask   = size_i == SZ_BYTE ? DATA_WIDTH'(8'hFF) :
                  size_i == SZ_HALF ? DATA_WIDTH'(16'hFFFF) : '1;
        err_o   = size_i == SZ_RSVD || (size_i == SZ_HALF && offs_i[0]) ||
                  (size_i == SZ_WORD && offs_i != 2'b00);
        sh      = {offs_i, 3'b000};
        be_o    = err_o ? 4'b0000 : mask << offs_i;
        // Upper store bits are masked so unused lanes never carry stale requester data.
        wdata_o = (wdata_i & dmask) << sh;
        rdata_o = err_o ? '0 : (rdata_i >> sh) & dmask;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single combinational-read data memory.
// Ports: clk_i, rst_i (async, active-high), bus (dmem_arbiter_if.slave: requests, responses, memory).
// Each accepted request runs IDLE -> ACCESS -> RESP (response at accept cycle + 2).
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic           clk_i,
    input logic           rst_i,
    dmem_arbiter_if.slave bus
);
    state_e                 state_q;
    logic                   sel_q, we_q, err_q;
    size_e                  size_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;
    logic [NUM_PORTS-1:0]   rsp_q, gnt;
    logic [3:0]             be;
    logic [DATA_WIDTH-1:0]  wsh, rext;
    logic                   err, idle, acc;

    // Reset gates the grant so ready is low for the whole reset pulse.
    assign idle = state_q == IDLE && !rst_i;
    assign acc  = state_q == ACCESS;

`ifdef DMEM_ARB_RR_EN
    logic last_q;
    assign gnt[0] = idle && bus.req0_valid_i && (!bus.req1_valid_i || last_q);
    assign gnt[1] = idle && bus.req1_valid_i && (!bus.req0_valid_i || !last_q);
`else
    assign gnt[0] = idle && bus.req0_valid_i;
    assign gnt[1] = idle && bus.req1_valid_i && !bus.req0_valid_i;
`endif

    dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size_i  (size_q),
        .offs_i  (addr_q[1:0]),
        .wdata_i (wdata_q),
        .rdata_i (bus.mem_rdata_i),
        .be_o    (be),
        .wdata_o (wsh),
        .rdata_o (rext),
        .err_o   (err)
    );

    assign bus.req0_ready_o = gnt[0];
    assign bus.req1_ready_o = gnt[1];
    assign bus.mem_we_o     = acc && we_q && !err;
    assign bus.mem_be_o     = acc ? be : 4'b0000;
    assign bus.mem_addr_o   = acc ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_wdata_o  = acc && we_q ? wsh : '0;
    assign bus.rsp0_valid_o = rsp_q[0];
    assign bus.rsp0_err_o   = rsp_q[0] && err_q;
    assign bus.rsp0_rdata_o = rsp_q[0] ? rdata_q : '0;
    assign bus.rsp1_valid_o = rsp_q[1];
    assign bus.rsp1_err_o   = rsp_q[1] && err_q;
    assign bus.rsp1_rdata_o = rsp_q[1] ? rdata_q : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: if (|gnt) begin
                    sel_q   <= gnt[1];
                    we_q    <= gnt[1] ? bus.req1_we_i : bus.req0_we_i;
                    size_q  <= size_e'(gnt[1] ? bus.req1_size_i : bus.req0_size_i);
                    addr_q  <= gnt[1] ? bus.req1_addr_i : bus.req0_addr_i;
                    wdata_q <= gnt[1] ? bus.req1_wdata_i : bus.req0_wdata_i;
                    state_q <= ACCESS;
`ifdef DMEM_ARB_RR_EN
                    last_q  <= gnt[1];
`endif
                end
                ACCESS: begin
                    rdata_q <= we_q ? '0 : rext;
                    err_q   <= err;
                    rsp_q   <= sel_q ? 2'b10 : 2'b01;
                    state_q <= RESP;
                end
                default: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    rsp_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a byte-enabled memory and a reference memory image.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    assign bus.mem_rdata_i = mem[bus.mem_addr_o[9:2]];

    always @(posedge clk)
        if (bus.mem_we_o)
            for (int b = 0; b < 4; b++)
                if (bus.mem_be_o[b]) mem[bus.mem_addr_o[9:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_err(input logic [1:0] sz, input logic [1:0] a);
        return sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a != 2'b00);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
        if (m_err(sz, a)) return 4'b0000;
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] sz);
        logic [31:0] w;
        int          a;
        w = ref_mem[addr[9:2]];
        a = int'(addr[1:0]);
        case (sz)
            2'b00:   return {24'h0, w[8*a +: 8]};
            2'b01:   return {16'h0, w[8*a +: 16]};
            default: return w;
        endcase
    endfunction

    task automatic m_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        logic [3:0] be;
        int         a;
        be = m_be(sz, addr[1:0]);
        a  = int'(addr[1:0]);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[addr[9:2]][8*b +: 8] = wd[8*(b-a) +: 8];
    endtask

    task automatic drive(input int p, input bit v, input bit we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus.req0_valid_i = v; bus.req0_we_i = we; bus.req0_size_i = sz;
            bus.req0_addr_i = a; bus.req0_wdata_i = wd;
        end else begin
            bus.req1_valid_i = v; bus.req1_we_i = we; bus.req1_size_i = sz;
            bus.req1_addr_i = a; bus.req1_wdata_i = wd;
        end
    endtask

    task automatic wait_rdy(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (bus.req0_ready_o || bus.req1_ready_o) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic push_exp(input int p, input bit we, input logic [1:0] sz, input logic [31:0] a);
        exp_t e;
        e.port  = p;
        e.err   = m_err(sz, a[1:0]);
        e.rdata = (we || e.err) ? 32'h0 : m_load(a, sz);
        e.cyc   = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic do_txn(input int p, input bit we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
        bit          ok, e;
        logic [31:0] m;
        @(negedge clk);
        drive(p, 1'b1, we, sz, a, wd);
        #1;
        wait_rdy(ok);
        check("ready_seen", 32'(ok), 1);
        if (ok) begin
            check("winner", 32'(bus.req1_ready_o), p);
            push_exp(p, we, sz, a);
            e = m_err(sz, a[1:0]);
            m = sz == 2'b00 ? 32'hFF : sz == 2'b01 ? 32'hFFFF : 32'hFFFF_FFFF;
            @(posedge clk);
            #1;
            drive(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            check("acc_be", 32'(bus.mem_be_o), 32'(m_be(sz, a[1:0])));
            check("acc_we", 32'(bus.mem_we_o), 32'(we && !e));
            check("acc_addr", bus.mem_addr_o, {a[31:2], 2'b00});
            if (we && !e) begin
                check("acc_wdata", bus.mem_wdata_o, (wd & m) << (8 * a[1:0]));
                m_store(a, sz, wd);
            end
            @(posedge clk);
            #1;
            check("resp_we", 32'(bus.mem_we_o), 0);
            check("resp_be", 32'(bus.mem_be_o), 0);
            @(posedge clk);
        end else drive(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("one_ready", 32'(bus.req0_ready_o & bus.req1_ready_o), 0);
            if (bus.rsp0_valid_o || bus.rsp1_valid_o) begin
                if (sb.size() == 0) check("unexpected_rsp", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("rsp_both", 32'(bus.rsp0_valid_o & bus.rsp1_valid_o), 0);
                    check("rsp_port", 32'(bus.rsp1_valid_o), e.port);
                    check("rsp_err", 32'(e.port == 1 ? bus.rsp1_err_o : bus.rsp0_err_o), 32'(e.err));
                    check("rsp_rdata", e.port == 1 ? bus.rsp1_rdata_o : bus.rsp0_rdata_o, e.rdata);
                    check("rsp_cycle", cyc, e.cyc);
                end
            end else
                check("idle_rsp_zero", {28'h0, bus.rsp0_err_o, bus.rsp1_err_o,
                                        |bus.rsp0_rdata_o, |bus.rsp1_rdata_o}, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          bad, w, exp_w;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        bus.req0_valid_i = 1'b1;
        #1;
        check("rst_ready0", 32'(bus.req0_ready_o), 0);
        check("rst_mem_we", 32'(bus.mem_we_o), 0);
        check("rst_mem_be", 32'(bus.mem_be_o), 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        check("rst_rsp", {30'h0, bus.rsp0_valid_o, bus.rsp1_valid_o}, 0);
        bus.req0_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_txn(0, 1'b1, 2'b10, 32'h0001_0004, 32'hDEAD_BEEF);
        do_txn(0, 1'b0, 2'b10, 32'h0001_0004, 32'h0);
        do_txn(0, 1'b1, 2'b10, 32'h0001_0004, 32'hAABB_CCDD);
        do_txn(1, 1'b0, 2'b00, 32'h0001_0007, 32'h0);
        do_txn(1, 1'b1, 2'b01, 32'h0001_0002, 32'h0000_1234);
        do_txn(0, 1'b0, 2'b01, 32'h0001_0002, 32'h0);
        do_txn(0, 1'b0, 2'b10, 32'h0001_0001, 32'h0);
        do_txn(1, 1'b0, 2'b11, 32'h0001_0000, 32'h0);
        do_txn(1, 1'b1, 2'b01, 32'h0001_0005, 32'h5555);
        do_txn(0, 1'b1, 2'b10, 32'h0001_0003, 32'h7777_7777);
        for (int i = 0; i < 24; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'h0001_0000 + 32'($urandom_range(0, 31));
            do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, a, $urandom);
        end

        // Reset during the ACCESS cycle of a store: nothing written, no response.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'b10, 32'h0001_0008, 32'hCAFE_F00D);
        #1;
        wait_rdy(ok);
        check("rst_txn_ready", 32'(ok), 1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        check("rst_txn_acc_we", 32'(bus.mem_we_o), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_we", 32'(bus.mem_we_o), 0);
        check("rst_mid_be", 32'(bus.mem_be_o), 0);
        check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Contested arbitration right after reset, both requesters always valid.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b10, 32'h0001_0004, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b00, 32'h0001_0000, 32'h0);
        #1;
        for (int i = 0; i < 4; i++) begin
            wait_rdy(ok);
            check("contest_ready", 32'(ok), 1);
            if (!ok) break;
            w = int'(bus.req1_ready_o);
`ifdef DMEM_ARB_RR_EN
            exp_w = i % 2;
`else
            exp_w = 0;
`endif
            check("contest_grant", w, exp_w);
            if (w == 1) push_exp(1, 1'b0, 2'b00, 32'h0001_0000);
            else push_exp(0, 1'b0, 2'b10, 32'h0001_0004);
            @(posedge clk);
            #1;
            if (i == 3) begin
                drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
                drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
            end
        end
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image", bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, for address width of both requesters and the memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, for the word width (4 byte lanes).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports reqN_valid_i (input, 1), request present, for N in {0,1}.
REQ-006 SHALL have ports reqN_ready_o (output, 1), request accepted this cycle.
REQ-007 SHALL have ports reqN_we_i (input, 1), 1 = store, 0 = load.
REQ-008 SHALL have ports reqN_size_i (input, 2): 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have ports reqN_addr_i (input, ADDR_WIDTH) and reqN_wdata_i (input, DATA_WIDTH), with store data right-justified.
REQ-010 SHALL have ports rspN_valid_o (output, 1), rspN_err_o (output, 1) and rspN_rdata_o (output, DATA_WIDTH), the completion strobe, the error flag and the load data.
REQ-011 SHALL have memory-side ports mem_we_o (output, 1), mem_be_o (output, 4), mem_addr_o (output, ADDR_WIDTH), mem_wdata_o (output, DATA_WIDTH) and mem_rdata_i (input, DATA_WIDTH); the memory has combinational read and byte-enabled write.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-013 SHALL, in IDLE with any reqN_valid_i high, assert reqN_ready_o for exactly one winner, latch its we/size/addr/wdata, and move to ACCESS on the next cycle.
REQ-014 SHALL never assert both ready outputs, and SHALL assert ready only in IDLE.
REQ-015 SHALL, in ACCESS, drive mem_addr_o = {addr[ADDR_WIDTH-1:2],2'b00}, mem_be_o = size mask shifted left by addr[1:0], and mem_wdata_o = wdata shifted left by 8*addr[1:0]; for stores it SHALL assert mem_we_o for exactly this one cycle.
REQ-016 SHALL, in ACCESS for a load, register (mem_rdata_i >> 8*addr[1:0]) masked to the size, zero-extended.
REQ-017 SHALL, in RESP, assert rspN_valid_o of the latched winner for one cycle, then return to IDLE; latency from accept cycle T to response is T+2, and throughput is one transaction per 3 cycles.
REQ-018 SHALL treat size 11, half with addr[0]=1, and word with addr[1:0]!=00 as errors: ACCESS issues no memory activity (mem_we_o=0, mem_be_o=0), and RESP asserts rspN_err_o=1 with rdata=0.
REQ-019 SHALL drive rdata=0 on store responses; rspN_rdata_o and rspN_err_o SHALL be 0 whenever rspN_valid_o is 0.
REQ-020 SHALL keep mem_we_o=0 and mem_be_o=0 outside ACCESS.
REQ-021 SHALL require each requester to hold its request inputs stable from valid until ready; a requester deasserting valid before ready SHALL lose nothing.

Reset
REQ-022 SHALL, on rst_i assertion at any time including mid-transaction, enter IDLE, clear all ready/valid/err/mem_we_o/mem_be_o outputs to 0, zero all data outputs, and discard the pending transaction with no response.
REQ-023 SHALL reset the last-grant register to port 1, so port 0 wins the first contested arbitration.

Configuration
REQ-024 SHALL, with DMEM_ARB_RR_EN defined, use round-robin: on simultaneous valids grant the port not granted last; the last-grant register updates on every accept.
REQ-025 SHALL, without DMEM_ARB_RR_EN, use fixed priority (port 0 always wins), and no last-grant register SHALL exist.

Structure
REQ-026 SHALL take the size encoding enum, the FSM state enum and the constant NUM_PORTS=2 from shared package dmem_pkg.
REQ-027 SHALL place the byte-lane shift, mask, byte-enable and misalignment logic in the combinational sub-module dmem_lane_align.

Verification
REQ-028 SHALL cover: port 0 stores word 0xDEADBEEF at 0x10004, then loads it -> mem_be_o=1111 and mem_we_o for one cycle; the load response returns 0xDEADBEEF at T+2.
REQ-029 SHALL cover: port 1 loads a byte at 0x10007 with mem word 0xAABBCCDD -> mem_be_o=1000, rsp1_rdata_o=0x000000AA.
REQ-030 SHALL cover: a half store 0x1234 at 0x10002 -> mem_be_o=1100, mem_wdata_o=0x12340000.
REQ-031 SHALL cover: both valid for 4 transactions with RR_EN defined -> grants 0,1,0,1; without the macro -> grants 0,0,0,0.
REQ-032 SHALL cover: a word load at 0x10001 -> no memory write, rsp_err_o=1, rdata=0; and rst_i pulsed during ACCESS of a store -> no rsp_valid, mem_we_o=0 immediately, FSM in IDLE.
